// File: rtl/divisor_peso_if.sv
// divisor_peso_if: request/response bundle for the weight divider.
//   master (requester): drives start, preco, precofr, centimos;
//                       observes busy, done, weightInGrams, overflow, divZero.
//   slave  (divider):   the reverse view.
interface divisor_peso_if;
  logic        start;
  logic [11:0] preco;          // whole euros
  logic [11:0] precofr;        // cents part
  logic [9:0]  centimos;       // unit price, cents per kg
  logic        busy;
  logic        done;
  logic [11:0] weightInGrams;
  logic        overflow;
  logic        divZero;

  modport master (
    output start, preco, precofr, centimos,
    input  busy, done, weightInGrams, overflow, divZero
  );

  modport slave (
    input  start, preco, precofr, centimos,
    output busy, done, weightInGrams, overflow, divZero
  );
endinterface

// File: rtl/divisor_peso.sv
// divisor_peso: price -> weight converter for "sell by amount" mode.
// Computes grams = ((preco*100 + precofr)*1000) / centimos with a 29-step
// restoring divider (one quotient bit per cycle, MSB first).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - divisor_peso_if.slave: start/operands in; busy, done pulse,
//           weightInGrams (saturated at 4095), overflow, divZero out.
module divisor_peso (
  input  logic           clk,
  input  logic           rst_n,
  divisor_peso_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIV, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_preco, r_precofr;
  logic [9:0]  r_cent;
  logic [28:0] r_num;          // numerator in milli-cents
  logic [28:0] r_q;            // quotient under construction
  logic [10:0] r_rem;          // partial remainder, always < r_cent
  logic [4:0]  r_k;            // current quotient bit index
  logic [11:0] r_wg;
  logic        r_ovf, r_dz;

  logic [18:0] w_cents;
  logic [28:0] w_num;
  logic [11:0] w_trial;
  logic        w_ge;
  logic [10:0] w_rem_nxt;
  logic [28:0] w_q_nxt;
  logic        w_busy, w_done;

  // Numerator: fits 29 bits even with precofr at its 12-bit maximum.
  assign w_cents = 19'(r_preco) * 19'd100 + 19'(r_precofr);
  assign w_num   = 29'(w_cents) * 29'd1000;

  // One restoring step: shift in the next numerator bit, subtract if it fits.
  assign w_trial   = {r_rem, r_num[r_k]};
  assign w_ge      = (w_trial >= {2'b00, r_cent});
  assign w_rem_nxt = w_ge ? 11'(w_trial - {2'b00, r_cent}) : w_trial[10:0];
  assign w_q_nxt   = r_q | (29'(w_ge) << r_k);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.start)       w_state_nxt = S_PREP;
      S_PREP: w_state_nxt = (r_cent == 10'd0) ? S_DONE : S_DIV;
      S_DIV:  if (r_k == 5'd0)     w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs, decoded from the state register only
  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_done = (r_state == S_DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_preco   <= '0;
      r_precofr <= '0;
      r_cent    <= '0;
      r_num     <= '0;
      r_q       <= '0;
      r_rem     <= '0;
      r_k       <= '0;
      r_wg      <= '0;
      r_ovf     <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_preco   <= bus.preco;
          r_precofr <= bus.precofr;
          r_cent    <= bus.centimos;
        end
        S_PREP: begin
          r_num <= w_num;
          r_rem <= '0;
          r_q   <= '0;
          r_k   <= 5'd28;
          if (r_cent == 10'd0) begin
            r_wg  <= '0;
            r_ovf <= 1'b0;
            r_dz  <= 1'b1;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_k   <= r_k - 5'd1;
          if (r_k == 5'd0) begin
            // Any quotient bit above 11 means the weight does not fit.
            if (w_q_nxt[28:12] != '0) begin
              r_wg  <= 12'hFFF;
              r_ovf <= 1'b1;
            end else begin
              r_wg  <= w_q_nxt[11:0];
              r_ovf <= 1'b0;
            end
            r_dz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.weightInGrams = r_wg;
  assign bus.overflow      = r_ovf;
  assign bus.divZero       = r_dz;

endmodule
